mem_arbiter: RTL and testbench

Arbitrates a single-port, variable-latency unified memory between the pipelined CPU's instruction-fetch port and data-access port (lw/sw in MEM stage). It sequences each access through a request/acknowledge memory handshake and returns per-requester ready pulses. It generates stall signals that freeze the pipeline registers while an access is outstanding. Data port has priority, bounded by a starvation limit so fetch always progresses.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between the CPU's
// instruction-fetch port and its data (load/store) port. Data accesses win
// arbitration, but only for a bounded run while fetch is waiting, so the
// pipeline can always fetch. Each access is a req/ack handshake with a
// watchdog that aborts a stuck access and flags a bus error.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // status
  output logic              bus_err,
  output logic              stall_if,
  output logic              stall_data
);

  localparam int RUN_W  = $clog2(MAX_D_RUN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // Run limit and last legal wait cycle, pre-sized to their counters.
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_D_RUN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [RUN_W-1:0]    run_cnt_q,  run_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                m_req_q,    m_req_d;
  logic                m_we_q,     m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q,  d_ready_d;
  logic                bus_err_q,  bus_err_d;

  // Data may take the port unless fetch is waiting and the data run is used up.
  logic d_grant;
  // The cycle in which a silent memory has exhausted its allowed wait.
  logic timeout_hit;
  // A completed (acked) or aborted access, either way the owner gets ready.
  logic access_done;
  // Memory is word addressed; byte offsets are dropped on purpose.
  logic unused_byte_offsets;

  assign d_grant             = d_req & (~if_req | (run_cnt_q < RUN_MAX));
  assign timeout_hit         = (wait_cnt_q == WAIT_LAST);
  assign access_done         = m_ack | timeout_hit;
  assign unused_byte_offsets = ^{if_addr[1:0], d_addr[1:0]};

  // Arbitration, handshake sequencing and result capture.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    wait_cnt_d = wait_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_grant) begin
          state_d    = BUSY_D;
          // Only runs taken while fetch waits count towards the limit.
          if (if_req) begin
            run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX
                                               : run_cnt_q + RUN_W'(1);
          end else begin
            run_cnt_d = '0;
          end
          wait_cnt_d = '0;
          m_req_d    = 1'b1;
          m_we_d     = d_we;
          m_addr_d   = {d_addr[ADDR_W-1:2], 2'b00};
          m_wdata_d  = d_wdata;
        end else if (if_req) begin
          state_d    = BUSY_IF;
          run_cnt_d  = '0;
          wait_cnt_d = '0;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
          m_wdata_d  = d_wdata;
        end else begin
          run_cnt_d  = '0;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (access_done) begin
          // An ack on the final wait cycle still wins over the abort.
          state_d    = IDLE;
          m_req_d    = 1'b0;
          wait_cnt_d = '0;
          bus_err_d  = ~m_ack;
          if (state_q == BUSY_D) begin
            d_ready_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_ack ? m_rdata : '0;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = m_ack ? m_rdata : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills any access in flight at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign bus_err  = bus_err_q;

  // Pipeline freezes for as long as a request is held and not yet answered.
  assign stall_if   = if_req & ~if_ready_q;
  assign stall_data = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the CPU and the memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;
  logic        stall_if;
  logic        stall_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err), .stall_if(stall_if), .stall_data(stall_data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge: outputs settled, inputs drivable.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step; step;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_m_req got=%b exp=0", m_req); end
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rst_m_we got=%b exp=0", m_we); end
    n_checks++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
    n_checks++; if (m_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_wdata got=%h exp=0", m_wdata); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    n_checks++; if ({if_ready, d_ready, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got=%b exp=000", {if_ready, d_ready, bus_err}); end
    reset = 1'b1;
    step;
    $display("reset: done");
  endtask

  task automatic test_single_load;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    #1;
    n_checks++; if (stall_data !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0 got=%b exp=1", stall_data); end
    step; // cycle 1: m_req up
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL load_m_req got=%b exp=1", m_req); end
    n_checks++; if (m_addr !== 32'h104) begin n_fail++; $display("FAIL load_m_addr got=%h exp=104", m_addr); end
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL load_m_we got=%b exp=0", m_we); end
    step; // cycle 2: still waiting
    n_checks++; if ({m_req, d_ready, stall_data} !== 3'b101) begin n_fail++; $display("FAIL load_wait got=%b exp=101", {m_req, d_ready, stall_data}); end
    step; // cycle 3: memory acks
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    step; // cycle 4: ready cycle
    m_ack = 1'b0;
    n_checks++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL load_d_ready got=%b exp=1", d_ready); end
    n_checks++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL load_d_rdata got=%h exp=cafef00d", d_rdata); end
    n_checks++; if ({m_req, stall_data} !== 2'b00) begin n_fail++; $display("FAIL load_release got=%b exp=00", {m_req, stall_data}); end
    d_req = 1'b0;
    step;
    n_checks++; if ({d_ready, m_req} !== 2'b00) begin n_fail++; $display("FAIL load_one_pulse got=%b exp=00", {d_ready, m_req}); end
    $display("load addr=104 rdata=%h", d_rdata);
  endtask

  task automatic test_contention;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h11223344;
    if_req = 1'b1; if_addr = 32'h0;
    step; // data wins
    n_checks++; if ({m_req, m_we} !== 2'b11) begin n_fail++; $display("FAIL cont_d_grant got=%b exp=11", {m_req, m_we}); end
    n_checks++; if (m_addr !== 32'h200) begin n_fail++; $display("FAIL cont_d_addr got=%h exp=200", m_addr); end
    n_checks++; if (m_wdata !== 32'h11223344) begin n_fail++; $display("FAIL cont_wdata got=%h exp=11223344", m_wdata); end
    n_checks++; if ({stall_if, stall_data} !== 2'b11) begin n_fail++; $display("FAIL cont_stalls got=%b exp=11", {stall_if, stall_data}); end
    m_ack = 1'b1; m_rdata = 32'h99999999;
    step;
    m_ack = 1'b0;
    n_checks++; if ({d_ready, if_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_d_ready got=%b exp=10", {d_ready, if_ready}); end
    n_checks++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cont_store_keeps_rdata got=%h exp=cafef00d", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    step; // fetch granted
    n_checks++; if ({m_req, m_we} !== 2'b10) begin n_fail++; $display("FAIL cont_if_grant got=%b exp=10", {m_req, m_we}); end
    n_checks++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL cont_if_addr got=%h exp=0", m_addr); end
    m_ack = 1'b1; m_rdata = 32'hA5A50001;
    step;
    m_ack = 1'b0;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL cont_if_ready got=%b exp=1", if_ready); end
    n_checks++; if (if_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL cont_if_rdata got=%h exp=a5a50001", if_rdata); end
    n_checks++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cont_d_rdata_held got=%h exp=cafef00d", d_rdata); end
    if_req = 1'b0;
    step;
    $display("contention: store 200 then fetch 0 rdata=%h", if_rdata);
  endtask

  task automatic test_starvation;
    logic exp_is_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic got_is_d [10];
    int   n = 0;
    int   cyc = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h80;
    while (n < 10 && cyc < 60) begin
      step;
      cyc++;
      if (m_req === 1'b1) begin
        got_is_d[n] = (m_addr === 32'h300);
        n++;
        m_ack = 1'b1; m_rdata = 32'h1000 + n;
      end else begin
        m_ack = 1'b0;
      end
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL starve_grant_count got=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (got_is_d[i] !== exp_is_d[i]) begin
        n_fail++; $display("FAIL starve_grant%0d got_d=%b exp_d=%b", i, got_is_d[i], exp_is_d[i]);
      end
    end
    step;
    m_ack = 1'b0;
    n_checks++; if ({if_ready, d_ready} !== 2'b10) begin n_fail++; $display("FAIL starve_last_if got=%b exp=10", {if_ready, d_ready}); end
    d_req = 1'b0; if_req = 1'b0;
    step;
    $display("starvation: %0d grants in %0d cycles", n, cyc);
  endtask

  task automatic test_timeout;
    int cnt = 0;
    int early = 0;
    if_req = 1'b1; if_addr = 32'h40; m_ack = 1'b0;
    step;
    n_checks++; if (m_addr !== 32'h40) begin n_fail++; $display("FAIL to_m_addr got=%h exp=40", m_addr); end
    while (m_req === 1'b1 && cnt < 40) begin
      if (if_ready !== 1'b0 || bus_err !== 1'b0) early++;
      cnt++;
      step;
    end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=16", cnt); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early_pulse got=%0d exp=0", early); end
    n_checks++; if ({if_ready, bus_err} !== 2'b11) begin n_fail++; $display("FAIL to_pulses got=%b exp=11", {if_ready, bus_err}); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL to_if_rdata got=%h exp=0", if_rdata); end
    if_req = 1'b0;
    step;
    n_checks++; if ({if_ready, bus_err, m_req} !== 3'b000) begin n_fail++; $display("FAIL to_after got=%b exp=000", {if_ready, bus_err, m_req}); end
    $display("timeout: fetch 40 aborted after %0d cycles", cnt);
  endtask

  task automatic test_ack_at_limit;
    int cnt = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    step;
    while (cnt < 16 && m_req === 1'b1) begin
      step;
      cnt++;
    end
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL lim_req_at_16 got=%b exp=1 cyc=%0d", m_req, cnt); end
    m_ack = 1'b1; m_rdata = 32'h5555AAAA;
    step;
    m_ack = 1'b0;
    n_checks++; if ({d_ready, bus_err} !== 2'b10) begin n_fail++; $display("FAIL lim_success got=%b exp=10", {d_ready, bus_err}); end
    n_checks++; if (d_rdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL lim_d_rdata got=%h exp=5555aaaa", d_rdata); end
    d_req = 1'b0;
    step;
    $display("ack on last wait cycle: load 10 rdata=%h", d_rdata);
  endtask

  task automatic test_misaligned_stray;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h107; d_wdata = 32'hDEADBEEF;
    step;
    n_checks++; if (m_addr !== 32'h104) begin n_fail++; $display("FAIL mis_m_addr got=%h exp=104", m_addr); end
    n_checks++; if ({m_req, m_we} !== 2'b11) begin n_fail++; $display("FAIL mis_req_we got=%b exp=11", {m_req, m_we}); end
    m_ack = 1'b1; m_rdata = 32'h77777777;
    step;
    m_ack = 1'b0;
    n_checks++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL mis_d_ready got=%b exp=1", d_ready); end
    d_req = 1'b0; d_we = 1'b0;
    step;
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    step;
    m_ack = 1'b0;
    n_checks++; if ({m_req, if_ready, d_ready, bus_err} !== 4'b0000) begin n_fail++; $display("FAIL stray_c1 got=%b exp=0000", {m_req, if_ready, d_ready, bus_err}); end
    step;
    n_checks++; if ({m_req, if_ready, d_ready, bus_err} !== 4'b0000) begin n_fail++; $display("FAIL stray_c2 got=%b exp=0000", {m_req, if_ready, d_ready, bus_err}); end
    n_checks++; if (d_rdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL stray_d_rdata got=%h exp=5555aaaa", d_rdata); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL stray_if_rdata got=%h exp=0", if_rdata); end
    $display("misaligned store 107 -> 104, stray ack ignored");
  endtask

  task automatic test_async_reset;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step;
    n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL ar_m_req_before got=%b exp=1", m_req); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL ar_m_req_drop got=%b exp=0", m_req); end
    step;
    n_checks++; if ({d_ready, bus_err} !== 2'b00) begin n_fail++; $display("FAIL ar_no_pulse got=%b exp=00", {d_ready, bus_err}); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL ar_d_rdata got=%h exp=0", d_rdata); end
    d_req = 1'b0;
    reset = 1'b1;
    step;
    n_checks++; if ({d_ready, m_req} !== 2'b00) begin n_fail++; $display("FAIL ar_after_release got=%b exp=00", {d_ready, m_req}); end
    if_req = 1'b1; if_addr = 32'h44;
    step;
    n_checks++; if ({m_req, m_we} !== 2'b10) begin n_fail++; $display("FAIL ar_if_grant got=%b exp=10", {m_req, m_we}); end
    n_checks++; if (m_addr !== 32'h44) begin n_fail++; $display("FAIL ar_if_addr got=%h exp=44", m_addr); end
    m_ack = 1'b1; m_rdata = 32'h600DCAFE;
    step;
    m_ack = 1'b0;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ar_if_ready got=%b exp=1", if_ready); end
    n_checks++; if (if_rdata !== 32'h600DCAFE) begin n_fail++; $display("FAIL ar_if_rdata got=%h exp=600dcafe", if_rdata); end
    if_req = 1'b0;
    step;
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL ar_if_one_pulse got=%b exp=0", if_ready); end
    $display("async reset mid-load, then fetch 44 rdata=%h", if_rdata);
  endtask

  // Backstop so a broken design can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    if_req  = 1'b0; if_addr = 32'h0;
    d_req   = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    m_rdata = 32'h0; m_ack = 1'b0;
    test_reset;
    test_single_load;
    test_contention;
    test_starvation;
    test_timeout;
    test_ack_at_limit;
    test_misaligned_stray;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
